// File: rtl/fmul_share_ctrl_pkg.sv
// Shared types and helpers for the float64_mul sharing controller.
// States are one-hot so each state decodes from a single flop.
package fmul_share_pkg;

  localparam int DEFAULT_DATA_W = 64;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ISSUE = 5'b00010,
    WAIT  = 5'b00100,
    RESP  = 5'b01000,
    FLUSH = 5'b10000
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmul_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after the
// pointer, wrapping past the top requester back to requester 0.
module rr_pick
  import fmul_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] w_sum;
  logic [IDX_W-1:0] w_pos;

  // One extra sum bit lets ptr+offset exceed NUM_REQ before the wrap subtract.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, i_ptr} + SUM_W'(i);
      if (w_sum >= SUM_W'(NUM_REQ)) begin
        w_sum = w_sum - SUM_W'(NUM_REQ);
      end
      w_pos = w_sum[IDX_W-1:0];
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/fmul_share_ctrl.sv
// Round-robin scheduler sharing one float64_mul core between NUM_REQ
// requesters; each product returns to its owner as a one-cycle pulse.
module fmul_share_ctrl
  import fmul_share_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      core_ap_start,
  input  logic                      core_ap_ready,
  input  logic                      core_ap_done,
  input  logic                      core_ap_idle,
  output logic [DATA_W-1:0]         core_a,
  output logic [DATA_W-1:0]         core_b,
  input  logic [DATA_W-1:0]         core_ap_return,
  output logic                      busy
);

  localparam int IDX_W = idxWidth(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_grant;
  logic [CNT_W-1:0]   r_count;
  logic               r_timed_out;
  logic               r_start;
  logic [DATA_W-1:0]  r_core_a;
  logic [DATA_W-1:0]  r_core_b;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_rsp_err;

  logic [NUM_REQ-1:0] w_grant_oh;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_timeout_hit;
  logic               w_flush_done;
  logic [DATA_W-1:0]  w_a_arr [NUM_REQ];
  logic [DATA_W-1:0]  w_b_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
    assign w_b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .i_req  (req_valid),
    .i_ptr  (r_rr_ptr),
    .o_grant(w_grant_oh),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_timeout_hit = (r_count == CNT_LAST);
  assign w_flush_done  = core_ap_idle | core_ap_done;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_any) w_next = ISSUE;
      ISSUE: if (core_ap_ready) w_next = core_ap_done ? RESP : WAIT;
      WAIT:  if (core_ap_done || w_timeout_hit) w_next = RESP;
      RESP:  w_next = r_timed_out ? FLUSH : IDLE;
      FLUSH: if (w_flush_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Start is a flop that mirrors "next state is ISSUE", so it can only be high in ISSUE.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_count     <= '0;
      r_timed_out <= 1'b0;
      r_start     <= 1'b0;
      r_core_a    <= '0;
      r_core_b    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= (w_next == ISSUE);
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_core_a <= w_a_arr[w_idx];
            r_core_b <= w_b_arr[w_idx];
            r_grant  <= w_idx;
            r_count  <= '0;
          end
        end
        ISSUE: begin
          if (core_ap_ready && core_ap_done) begin
            r_rsp_data <= core_ap_return;
            r_rsp_err  <= 1'b0;
          end
        end
        WAIT: begin
          // A done arriving on the limit cycle still counts as success.
          if (core_ap_done) begin
            r_rsp_data <= core_ap_return;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout_hit) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_timed_out <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        RESP: begin
          r_rr_ptr <= (r_grant == IDX_LAST) ? '0 : r_grant + 1'b1;
        end
        FLUSH: begin
          if (w_flush_done) r_timed_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = (r_state == IDLE) ? w_grant_oh : '0;
  assign rsp_valid     = (r_state == RESP) ? (NUM_REQ'(1) << r_grant) : '0;
  assign rsp_data      = r_rsp_data;
  assign rsp_err       = r_rsp_err;
  assign core_ap_start = r_start;
  assign core_a        = r_core_a;
  assign core_b        = r_core_b;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_fmul_share_ctrl.sv
// Directed bench for fmul_share_ctrl with a behavioural float64_mul model
// and an accept-time scoreboard checked against every response pulse.
module tb_fmul_share_ctrl;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 64;
  localparam int TIMEOUT_CYC = 16;

  logic                      ap_clk = 1'b0;
  logic                      ap_rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      core_ap_start;
  logic                      core_ap_ready;
  logic                      core_ap_done;
  logic                      core_ap_idle;
  logic [DATA_W-1:0]         core_a;
  logic [DATA_W-1:0]         core_b;
  logic [DATA_W-1:0]         core_ap_return;
  logic                      busy;

  always #5 ap_clk = ~ap_clk;

  fmul_share_ctrl #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .core_ap_start (core_ap_start),
    .core_ap_ready (core_ap_ready),
    .core_ap_done  (core_ap_done),
    .core_ap_idle  (core_ap_idle),
    .core_a        (core_a),
    .core_b        (core_b),
    .core_ap_return(core_ap_return),
    .busy          (busy)
  );

  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic logic [63:0] genA(input int i, input int k);
    return $realtobits(1.5 + real'(i) + 0.25 * real'(k));
  endfunction

  function automatic logic [63:0] genB(input int i, input int k);
    return $realtobits(2.0 + 0.5 * real'(i) - 0.125 * real'(k));
  endfunction

  // Core model: accepts immediately, done L cycles after acceptance (L=0 is combinational).
  int          coreLat  = 5;
  logic        coreHang = 1'b0;
  logic        forceDone = 1'b0;
  int          coreCnt  = 0;
  logic [63:0] coreResult = '0;

  assign core_ap_ready  = core_ap_start;
  assign core_ap_done   = forceDone | (!coreHang & ((coreLat == 0) ? core_ap_start : (coreCnt == 1)));
  assign core_ap_return = forceDone ? 64'hDEAD_BEEF_DEAD_BEEF :
                          ((coreLat == 0) ? fmul(core_a, core_b) : coreResult);
  assign core_ap_idle   = !coreHang && (coreCnt == 0);

  always @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      coreCnt <= 0;
    end else if (core_ap_start && core_ap_ready && !coreHang && coreLat != 0) begin
      coreCnt    <= coreLat;
      coreResult <= fmul(core_a, core_b);
    end else if (coreCnt > 0) begin
      coreCnt <= coreCnt - 1;
    end
  end

  typedef struct {
    int          idx;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t               expQ[$];
  int                 acceptOrder[$];
  logic [63:0]        opA[NUM_REQ];
  logic [63:0]        opB[NUM_REQ];
  int                 remaining[NUM_REQ];
  int                 opSeq[NUM_REQ];
  logic [NUM_REQ-1:0] dropMask = '0;
  logic               expectTimeout = 1'b0;
  logic               prevStart = 1'b0;
  int                 testsRun = 0;
  int                 testsFailed = 0;
  int                 cyc = 0;
  int                 acceptCount = 0;
  int                 rspCount = 0;
  int                 lastAcceptCycle = 0;
  int                 lastRspCycle = 0;
  int                 startRiseCycle = 0;
  logic [63:0]        lastRspData = '0;
  logic               lastRspErr = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic packOperands();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*DATA_W +: DATA_W] = opA[i];
      req_b[i*DATA_W +: DATA_W] = opB[i];
    end
  endtask

  task automatic raiseReq(input int i, input int count, input logic [63:0] a, input logic [63:0] b);
    remaining[i] = count;
    opA[i]       = a;
    opB[i]       = b;
    packOperands();
    req_valid[i] = 1'b1;
  endtask

  // Sampled at the falling edge: record accepts into the scoreboard, check responses.
  task automatic checkOutput();
    exp_t e;
    if (core_ap_start && !prevStart) startRiseCycle = cyc;
    prevStart = core_ap_start;
    if (req_ready != '0) begin
      check("ready_onehot", 64'($countones(req_ready)), 64'd1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) begin
          acceptOrder.push_back(i);
          acceptCount++;
          lastAcceptCycle = cyc;
          dropMask[i] = 1'b1;
          e.idx  = i;
          e.data = expectTimeout ? 64'd0 : fmul(opA[i], opB[i]);
          e.err  = expectTimeout;
          expQ.push_back(e);
        end
      end
    end
    if (rsp_valid != '0) begin
      rspCount++;
      lastRspCycle = cyc;
      lastRspData  = rsp_data;
      lastRspErr   = rsp_err;
      if (expQ.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        e = expQ.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  endtask

  // One clock per iteration; returns just after the rising edge with inputs updated.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge ap_clk);
      checkOutput();
      @(posedge ap_clk);
      cyc++;
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (dropMask[i]) begin
          remaining[i]--;
          if (remaining[i] > 0) begin
            opSeq[i]++;
            opA[i] = genA(i, opSeq[i]);
            opB[i] = genB(i, opSeq[i]);
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      dropMask = '0;
      packOperands();
    end
  endtask

  task automatic waitResponses(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (rspCount < target && n < budget) begin
      applyStimulus(1);
      n++;
    end
    check({tag, "_rsp_count"}, 64'(rspCount), 64'(target));
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_data"}, rsp_data, 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_start"}, 64'(core_ap_start), 64'd0);
    check({tag, "_core_a"}, core_a, 64'd0);
    check({tag, "_core_b"}, core_b, 64'd0);
  endtask

  task automatic pulseReset();
    ap_rst_n = 1'b0;
    applyStimulus(1);
    ap_rst_n = 1'b1;
    expQ.delete();
    prevStart = 1'b0;
  endtask

  initial begin
    int base;
    int rspBefore;
    ap_rst_n  = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      opA[i] = '0;
      opB[i] = '0;
      remaining[i] = 0;
      opSeq[i] = 0;
    end
    packOperands();

    repeat (2) @(posedge ap_clk);
    #1;
    checkResetState("reset");
    ap_rst_n = 1'b1;

    // Single request, latency 5: 2.0 * 3.0.
    raiseReq(0, 1, 64'h4000000000000000, 64'h4008000000000000);
    waitResponses(1, 30, "single");
    check("single_grant", 64'(acceptOrder[0]), 64'd0);
    check("single_start_lat", 64'(startRiseCycle - lastAcceptCycle), 64'd1);
    check("single_rsp_lat", 64'(lastRspCycle - lastAcceptCycle), 64'd7);
    check("single_data", lastRspData, 64'h4018000000000000);
    check("single_err", 64'(lastRspErr), 64'd0);

    // All four at once from a fresh pointer, then wrap back to requester 0.
    pulseReset();
    acceptOrder.delete();
    for (int i = 0; i < NUM_REQ; i++) raiseReq(i, 1, genA(i, 0), genB(i, 0));
    waitResponses(rspCount + 4, 80, "all4");
    for (int i = 0; i < NUM_REQ; i++) check($sformatf("all4_order%0d", i), 64'(acceptOrder[i]), 64'(i));
    raiseReq(3, 1, genA(3, 7), genB(3, 7));
    raiseReq(0, 1, genA(0, 7), genB(0, 7));
    waitResponses(rspCount + 2, 40, "wrap");
    check("wrap_first", 64'(acceptOrder[4]), 64'd0);
    check("wrap_second", 64'(acceptOrder[5]), 64'd3);

    // Requester 1 keeps re-requesting; requester 2 must not be skipped.
    acceptOrder.delete();
    raiseReq(1, 3, genA(1, 1), genB(1, 1));
    raiseReq(2, 1, genA(2, 1), genB(2, 1));
    waitResponses(rspCount + 4, 120, "fair");
    check("fair_order0", 64'(acceptOrder[0]), 64'd1);
    check("fair_order1", 64'(acceptOrder[1]), 64'd2);
    check("fair_order2", 64'(acceptOrder[2]), 64'd1);
    check("fair_order3", 64'(acceptOrder[3]), 64'd1);

    // Hung core: timeout response, then no grants until the core releases.
    acceptOrder.delete();
    coreHang      = 1'b1;
    expectTimeout = 1'b1;
    raiseReq(3, 1, genA(3, 2), genB(3, 2));
    waitResponses(rspCount + 1, 40, "timeout");
    expectTimeout = 1'b0;
    check("timeout_rsp_lat", 64'(lastRspCycle - lastAcceptCycle), 64'(TIMEOUT_CYC + 2));
    check("timeout_err", 64'(lastRspErr), 64'd1);
    check("timeout_data", lastRspData, 64'd0);
    base = acceptCount;
    raiseReq(0, 1, genA(0, 3), genB(0, 3));
    applyStimulus(5);
    check("flush_no_grant", 64'(acceptCount), 64'(base));
    check("flush_busy", 64'(busy), 64'd1);
    rspBefore = rspCount;
    forceDone = 1'b1;
    applyStimulus(1);
    forceDone = 1'b0;
    coreHang  = 1'b0;
    applyStimulus(1);
    check("late_done_discarded", 64'(rspCount), 64'(rspBefore));
    waitResponses(rspCount + 1, 30, "after_flush");
    check("after_flush_grant", 64'(acceptOrder[acceptOrder.size() - 1]), 64'd0);

    // Reset in the middle of WAIT abandons the operation silently.
    coreLat = 5;
    base = acceptCount;
    raiseReq(3, 1, genA(3, 4), genB(3, 4));
    for (int n = 0; n < 10 && acceptCount == base; n++) applyStimulus(1);
    applyStimulus(3);
    pulseReset();
    checkResetState("midwait");
    rspBefore = rspCount;
    applyStimulus(8);
    check("midwait_no_rsp", 64'(rspCount), 64'(rspBefore));
    acceptOrder.delete();
    raiseReq(2, 1, genA(2, 5), genB(2, 5));
    raiseReq(0, 1, genA(0, 5), genB(0, 5));
    waitResponses(rspCount + 2, 40, "post_reset");
    check("post_reset_first", 64'(acceptOrder[0]), 64'd0);
    check("post_reset_second", 64'(acceptOrder[1]), 64'd2);

    // Combinational core: ready and done together skip WAIT.
    coreLat = 0;
    raiseReq(1, 1, genA(1, 6), genB(1, 6));
    waitResponses(rspCount + 1, 20, "comb");
    check("comb_rsp_lat", 64'(lastRspCycle - lastAcceptCycle), 64'd2);

    applyStimulus(2);
    check("scoreboard_empty", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
